// File: rtl/product_engine.sv
// Memory-mapped shift-add multiply engine: walks count records {A, B, P_hi, P_lo}
// from start_address and writes each 2*WIDTH-bit product back into its record.
module product_engine #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_address,
  input  logic [7:0]        i_count,
  input  logic              i_signed_mode,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [WIDTH-1:0]  i_mem_rd_data,
  output logic              o_mem_wr_en,
  output logic [WIDTH-1:0]  o_mem_wr_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_LOAD, S_MUL, S_WR_HI, S_WR_LO, S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [7:0]          r_left;
  logic                r_sm;
  logic [WIDTH-1:0]    r_a;
  logic [2*WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]    r_mplier;
  logic [2*WIDTH-1:0]  r_acc;
  logic                r_neg;
  logic [CW-1:0]       r_cnt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_wr_en;
  logic [WIDTH-1:0]    r_wr_data;
  logic                r_busy;
  logic                r_done;

  logic                w_a_neg, w_b_neg;
  logic [WIDTH-1:0]    w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0]  w_acc_sum, w_prod;

  // Magnitudes are unsigned WIDTH-bit, so the most negative operand maps to 2^(WIDTH-1).
  assign w_a_neg   = r_sm & r_a[WIDTH-1];
  assign w_b_neg   = r_sm & i_mem_rd_data[WIDTH-1];
  assign w_a_mag   = w_a_neg ? -r_a : r_a;
  assign w_b_mag   = w_b_neg ? -i_mem_rd_data : i_mem_rd_data;
  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod    = r_neg ? -w_acc_sum : w_acc_sum;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_left     <= '0;
      r_sm       <= 1'b0;
      r_a        <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_neg      <= 1'b0;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_busy     <= 1'b1;
            r_base     <= i_start_address;
            r_left     <= i_count;
            r_sm       <= i_signed_mode;
            r_mem_addr <= i_start_address;
            if (i_count == 8'd0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RD_A;
            end
          end
        end
        S_RD_A: begin
          r_mem_addr <= r_base + ADDR_W'(1);
          r_state    <= S_RD_B;
        end
        S_RD_B: begin
          r_a     <= i_mem_rd_data;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
          r_mplier <= w_b_mag;
          r_neg    <= w_a_neg ^ w_b_neg;
          r_acc    <= '0;
          r_cnt    <= CW'(WIDTH);
          r_state  <= S_MUL;
        end
        S_MUL: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          // Last step: fold in the sign and present the high word straight away.
          if (r_cnt == CW'(1)) begin
            r_acc      <= w_prod;
            r_mem_addr <= r_base + ADDR_W'(2);
            r_wr_data  <= w_prod[2*WIDTH-1:WIDTH];
            r_wr_en    <= 1'b1;
            r_state    <= S_WR_HI;
          end
        end
        S_WR_HI: begin
          r_mem_addr <= r_base + ADDR_W'(3);
          r_wr_data  <= r_acc[WIDTH-1:0];
          r_wr_en    <= 1'b1;
          r_state    <= S_WR_LO;
        end
        S_WR_LO: begin
          r_left <= r_left - 8'd1;
          r_base <= r_base + ADDR_W'(4);
          if (r_left > 8'd1) begin
            r_mem_addr <= r_base + ADDR_W'(4);
            r_state    <= S_RD_A;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wr_en   = r_wr_en;
  assign o_mem_wr_data = r_wr_data;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: doc/product_engine.md
# product_engine

Memory-mapped multiply accelerator for the product program. On a start pulse it walks a list of operand records in data memory, computes each WIDTH×WIDTH product with a multi-cycle shift-add datapath, and writes the 2·WIDTH-bit result back into the record. It generalises the fixed 8-bit, single-run product flow with:
- parametrised operand width;
- a record count;
- a signed/unsigned mode;
- an explicit busy/done handshake.

It sits beside the core on the data-memory port and is driven by the same start/start_address/done protocol as `top`.

## Interface
- WIDTH, 8, operand width in bits; product is 2·WIDTH bits, written as two words.
- ADDR_W, 8, data-memory address width.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_address  in  ADDR_W  address of record 0.
- count  in  8  number of records to process; 0 is legal.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_rd_data  in  WIDTH  read data. The memory is a synchronous read: data is valid the cycle after mem_addr is presented.
- mem_wr_en  out  1  write strobe, registered.
- mem_wr_data  out  WIDTH  write data, registered.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when all records are finished.

## Operation
- Record i occupies 4 consecutive words at base = start_address + 4·i: A, B, P_hi, P_lo.
- All address arithmetic is modulo 2^ADDR_W, so records wrap from the top of memory to address 0.
- start_address, count and signed_mode are latched on acceptance. Later input changes have no effect until the next run.
- States and transitions:
  - IDLE → RD_A on start. If count == 0, IDLE → DONE instead.
  - RD_A: mem_addr = base. → RD_B.
  - RD_B: mem_addr = base+1; capture A from mem_rd_data. → LOAD.
  - LOAD: capture B. In signed mode, convert A and B to magnitudes and record sign = A[msb] XOR B[msb]. Clear the accumulator and load the bit counter with WIDTH. → MUL.
  - MUL: each cycle, if the multiplier LSB is 1 add the multiplicand into the accumulator; shift; decrement the counter. After WIDTH cycles → WR_HI. In signed mode, if sign = 1, negate the 2·WIDTH-bit result on exit.
  - WR_HI: mem_addr = base+2, mem_wr_data = P[2W-1:W], mem_wr_en = 1. → WR_LO.
  - WR_LO: mem_addr = base+3, mem_wr_data = P[W-1:0], mem_wr_en = 1. Decrement the remaining-record count and advance base by 4. → RD_A if records remain, else → DONE.
  - DONE: done = 1. → IDLE.
- Arithmetic:
  - The unsigned product is exact.
  - In signed mode the magnitude of the most negative value (e.g. −128 at WIDTH = 8) is represented as an unsigned WIDTH-bit value. The 2·WIDTH-bit signed product is exact for all inputs.
- The engine never writes the A or B words of a record.
- start is ignored while busy = 1. There is no queuing.

## Timing
- Reset values: busy 0, done 0, mem_wr_en 0, mem_addr 0, mem_wr_data 0; state IDLE.
- Reset applies at any state. It takes effect on the next edge: no further writes are issued, and a partial record is left with whatever has already been written.
- Start acceptance: start high at IDLE edge k gives busy = 1 after edge k.
- Per-record latency is WIDTH+5 cycles (RD_A, RD_B, LOAD, WIDTH×MUL, WR_HI, WR_LO).
- done is high for exactly the cycle after the final WR_LO, i.e. count·(WIDTH+5)+1 cycles after acceptance.
- busy falls together with done, on the edge leaving DONE.
- count = 0: done is high in the cycle after acceptance, with no memory writes.
- A start asserted in the DONE cycle is ignored. A new start is accepted from the first IDLE cycle.
- mem_wr_en is high only in WR_HI and WR_LO, giving exactly 2 write cycles per record.

## Test plan
- Unsigned max: mem[0x10]=0xFF, mem[0x11]=0xFF, signed_mode 0, count 1, start_address 0x10 → mem[0x12]=0xFE, mem[0x13]=0x01. done rises 14 cycles after acceptance.
- Signed extremes: signed_mode 1 with (0x80, 0x80) → 0x40, 0x00. With (0xFD, 0x05) → 0xFF, 0xF1. With (0x7F, 0x80) → 0xC0, 0x80.
- Multi-record wrap: start_address 0xFC, count 3. Records sit at 0xFC, 0x00, 0x04 with pairs (2,3), (0,0xAB), (0x10,0x10). Results:
  - mem[0xFE..0xFF] = 0x00, 0x06;
  - mem[0x02..0x03] = 0x00, 0x00;
  - mem[0x06..0x07] = 0x01, 0x00;
  - done after 40 cycles.
- count = 0: start → done pulses in the next cycle, mem_wr_en never asserts, busy high for 1 cycle.
- Reset mid-MUL: assert reset during cycle 3 of MUL → next cycle busy 0, mem_wr_en 0, state IDLE, no writes to P_hi/P_lo. A following start completes correctly.
- Start while busy: pulse start with a different start_address during MUL → ignored. The original run completes and only one done pulse is seen.
